// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_pkg
// Description : Shared FPU types. Holds the IEEE-754 exception status record
//               returned by an operation group alongside each result.
// Revision    : 1.0 - initial release
// ============================================================================
package fpnew_pkg;

    // IEEE-754 exception flags: invalid, divide-by-zero, overflow,
    // underflow, inexact.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of_;
        logic uf;
        logic nx;
    } status_t;

endpackage
`default_nettype wire

// File: rtl/fpnew_result_reorder.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_result_reorder
// Description : Issues operations into an FPU operation group, tagging each
//               with a reorder-slot index, collects the out-of-order results
//               and retires them to the core strictly in issue order.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   in_valid_i/in_ready_o     core issue handshake, in_user_i sideband
//   fpu_in_valid_o/_ready_i   issue handshake towards the group
//   fpu_tag_o                 slot index attached to the issued op
//   fpu_out_valid_i/_ready_o  completion handshake from the group
//   fpu_result_i, fpu_status_i, fpu_ext_bit_i, fpu_tag_i  completion data
//   out_valid_o/out_ready_i   in-order retire handshake
//   result_o, status_o, extension_bit_o, user_o            retired data
//   flush_i                   discard all outstanding operations
//   busy_o                    at least one slot allocated
// ============================================================================
module fpnew_result_reorder
    import fpnew_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 4,
    parameter type         UserType = logic,
    localparam int unsigned IdxW    = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // core issue side
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  UserType          in_user_i,
    // operation group issue side
    output logic             fpu_in_valid_o,
    input  logic             fpu_in_ready_i,
    output logic [IdxW-1:0]  fpu_tag_o,
    // operation group completion side
    input  logic             fpu_out_valid_i,
    output logic             fpu_out_ready_o,
    input  logic [Width-1:0] fpu_result_i,
    input  status_t          fpu_status_i,
    input  logic             fpu_ext_bit_i,
    input  logic [IdxW-1:0]  fpu_tag_i,
    // in-order retire side
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] result_o,
    output status_t          status_o,
    output logic             extension_bit_o,
    output UserType          user_o,
    // control
    input  logic             flush_i,
    output logic             busy_o
);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
        UserType          user;
    } slot_t;

    localparam logic [IdxW:0] PTR_ONE = {{IdxW{1'b0}}, 1'b1};

    slot_t            slots [Depth];
    logic [Depth-1:0] alloc;
    logic [Depth-1:0] done;
    logic [IdxW:0]    wr_ptr;
    logic [IdxW:0]    rd_ptr;

    logic [IdxW-1:0]  wr_idx;
    logic [IdxW-1:0]  rd_idx;
    logic             empty;
    logic             full;
    logic             issue_fire;
    logic             cmpl_fire;
    logic             retire_fire;

    assign wr_idx = wr_ptr[IdxW-1:0];
    assign rd_idx = rd_ptr[IdxW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[IdxW] != rd_ptr[IdxW]);

    // Full is evaluated on current pointers only, so a retire in the same
    // cycle does not free a slot for issue until the next cycle.
    assign fpu_in_valid_o = in_valid_i & ~full;
    assign in_ready_o     = fpu_in_ready_i & ~full & ~flush_i;
    assign fpu_tag_o      = wr_idx;
    assign issue_fire     = in_valid_i & in_ready_o;

    // Every in-flight op owns a slot, so completions can always be accepted.
    // Stray results (unallocated or already-done slot) are dropped.
    assign fpu_out_ready_o = 1'b1;
    assign cmpl_fire       = fpu_out_valid_i & alloc[fpu_tag_i] & ~done[fpu_tag_i];

    assign out_valid_o     = ~empty & done[rd_idx];
    assign retire_fire     = out_valid_o & out_ready_i;
    assign result_o        = slots[rd_idx].result;
    assign status_o        = slots[rd_idx].status;
    assign extension_bit_o = slots[rd_idx].ext_bit;
    assign user_o          = slots[rd_idx].user;
    assign busy_o          = ~empty;

    // Issue, completion and retire always target distinct slots: issue hits
    // a free slot, completion an allocated not-done slot, retire a done slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            alloc  <= '0;
            done   <= '0;
            for (int i = 0; i < Depth; i++) begin
                slots[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            alloc  <= '0;
            done   <= '0;
        end else begin
            if (issue_fire) begin
                alloc[wr_idx]      <= 1'b1;
                done[wr_idx]       <= 1'b0;
                slots[wr_idx].user <= in_user_i;
                wr_ptr             <= wr_ptr + PTR_ONE;
            end
            if (cmpl_fire) begin
                done[fpu_tag_i]          <= 1'b1;
                slots[fpu_tag_i].result  <= fpu_result_i;
                slots[fpu_tag_i].status  <= fpu_status_i;
                slots[fpu_tag_i].ext_bit <= fpu_ext_bit_i;
            end
            if (retire_fire) begin
                alloc[rd_idx] <= 1'b0;
                done[rd_idx]  <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_ONE;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && !flush_i && fpu_out_valid_i) begin
            assert (alloc[fpu_tag_i] && !done[fpu_tag_i])
                else $error("fpnew_result_reorder: result for free or completed slot %0d", fpu_tag_i);
        end
    end
`endif

endmodule
`default_nettype wire
